lsu_master: RTL and testbench

LSU_MASTER -- requirements
Module: lsu_master

---
 rtl/lsu_master_if.sv | 35 +++
 rtl/lsu_master.sv | 182 ++++++++++++++++++
 tb/tb_lsu_master.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_master_if.sv
// CPU request/response and memory-side handshake bundle for lsu_master.
// master modport is the LSU's view; slave modport is the CPU/memory environment's view.
interface lsu_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
    );

    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/lsu_master.sv
// RV32I load/store unit: aligns stores onto word lanes, extracts/extends loads, flags errors and timeouts.
// Latency accept->resp (inclusive): store 3, load 4, error 2; one request in flight, req_ready only in IDLE.
module lsu_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_master_if.master  bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          write_q, write_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    a_q, a_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_ready_q, req_ready_d;
    logic          mem_valid_q, mem_valid_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [3:0]    mem_wstrb_q, mem_wstrb_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic [1:0]    resp_err_q, resp_err_d;

    logic          illegal, misalign, tmo_hit;
    logic [CW-1:0] cnt_inc;
    logic [31:0]   rshift, ext;
    logic [31:0]   lane_wdata;
    logic [3:0]    lane_wstrb;

    assign illegal = bus.req_write ? !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010})
                                   :  (bus.req_funct3 inside {3'b011, 3'b110, 3'b111});
    assign misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));

    assign cnt_inc = cnt_q + CW'(1);
    assign tmo_hit = (cnt_inc >= CW'(TIMEOUT_CYCLES));

    always_comb begin
        lane_wdata = bus.req_wdata;
        lane_wstrb = 4'b1111;
        case (bus.req_funct3[1:0])
            2'b00: begin
                lane_wdata = {4{bus.req_wdata[7:0]}};
                lane_wstrb = 4'b0001 << bus.req_addr[1:0];
            end
            2'b01: begin
                lane_wdata = {2{bus.req_wdata[15:0]}};
                lane_wstrb = 4'b0011 << bus.req_addr[1:0];
            end
            default: ;
        endcase
        if (!bus.req_write) begin
            lane_wstrb = 4'b0000;
        end
    end

    assign rshift = bus.mem_rdata >> {a_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  ext = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  ext = {{16{rshift[15]}}, rshift[15:0]};
            3'b100:  ext = {24'b0, rshift[7:0]};
            3'b101:  ext = {16'b0, rshift[15:0]};
            default: ext = rshift;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        f3_d         = f3_q;
        a_d          = a_q;
        cnt_d        = cnt_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = '0;
        resp_err_d   = '0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    write_d = bus.req_write;
                    f3_d    = bus.req_funct3;
                    a_d     = bus.req_addr[1:0];
                    if (illegal) begin
                        state_d    = RESP;
                        resp_err_d = 2'b10;
                    end else if (misalign) begin
                        state_d    = RESP;
                        resp_err_d = 2'b01;
                    end else begin
                        state_d     = REQ;
                        cnt_d       = '0;
                        mem_we_d    = bus.req_write;
                        mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                        mem_wstrb_d = lane_wstrb;
                        mem_wdata_d = lane_wdata;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_inc;
                // A handshake in the final allowed cycle still completes normally.
                if (bus.mem_ready) begin
                    state_d = write_q ? RESP : WAIT;
                end else if (tmo_hit) begin
                    state_d    = RESP;
                    resp_err_d = 2'b11;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (bus.mem_rvalid) begin
                    state_d      = RESP;
                    resp_rdata_d = ext;
                end else if (tmo_hit) begin
                    state_d    = RESP;
                    resp_err_d = 2'b11;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d  = (state_d == IDLE);
        mem_valid_d  = (state_d == REQ);
        resp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            f3_q         <= '0;
            a_q          <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            f3_q         <= f3_d;
            a_q          <= a_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.mem_valid  = mem_valid_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wstrb  = mem_wstrb_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_lsu_master.sv
// Directed bench for lsu_master: lanes, extraction, errors, timeout, mid-transaction reset, back-to-back.
module tb_lsu_master;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    lsu_master_if bus();

    lsu_master #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access: waits for req_ready, issues the request, observes until resp_valid.
    // lat counts accept cycle through resp_valid cycle inclusive; 0 means no response seen.
    task automatic run(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rd,
                       output int lat, output logic [31:0] rdata, output logic [1:0] err,
                       output int mv_cnt, output logic [31:0] maddr, output logic [31:0] mwdata,
                       output logic [3:0] mstrb, output logic mwe);
        lat = 0; rdata = 'x; err = 'x; mv_cnt = 0;
        maddr = 'x; mwdata = 'x; mstrb = 'x; mwe = 1'bx;
        for (int k = 0; k < 10 && !bus.req_ready; k++) begin
            @(posedge clk); #1;
        end
        bus.mem_rdata  = rd;
        bus.mem_rvalid = !w;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (bus.mem_valid) begin
                if (mv_cnt == 0) begin
                    maddr = bus.mem_addr; mwdata = bus.mem_wdata;
                    mstrb = bus.mem_wstrb; mwe = bus.mem_we;
                end
                mv_cnt++;
            end
            if (bus.resp_valid) begin
                lat = i + 1; rdata = bus.resp_rdata; err = bus.resp_err;
                break;
            end
            @(posedge clk); #1;
        end
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready got %b exp 1", bus.req_ready); end
        tests++; if (bus.mem_valid !== 1'b0) begin fails++; $display("FAIL rst_mem_valid got %b exp 0", bus.mem_valid); end
        tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid got %b exp 0", bus.resp_valid); end
        tests++; if (bus.mem_wstrb !== 4'b0) begin fails++; $display("FAIL rst_mem_wstrb got %b exp 0000", bus.mem_wstrb); end
        tests++; if (bus.resp_err !== 2'b0) begin fails++; $display("FAIL rst_resp_err got %b exp 00", bus.resp_err); end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_stores();
        int lat, mv; logic [31:0] rd, ma, mw; logic [1:0] e; logic [3:0] ms; logic we;
        run(1'b1, 3'b000, 32'h103, 32'hAABBCCDD, 32'h0, lat, rd, e, mv, ma, mw, ms, we);
        tests++; if (lat !== 3) begin fails++; $display("FAIL sb_latency got %0d exp 3", lat); end
        tests++; if (ma !== 32'h100) begin fails++; $display("FAIL sb_addr got %h exp 00000100", ma); end
        tests++; if (ms !== 4'b1000) begin fails++; $display("FAIL sb_wstrb got %b exp 1000", ms); end
        tests++; if (mw !== 32'hDDDDDDDD) begin fails++; $display("FAIL sb_wdata got %h exp dddddddd", mw); end
        tests++; if (we !== 1'b1) begin fails++; $display("FAIL sb_we got %b exp 1", we); end
        tests++; if (e !== 2'b00 || rd !== 32'h0) begin fails++; $display("FAIL sb_resp got err=%b rdata=%h exp 00/0", e, rd); end
        run(1'b1, 3'b001, 32'h12, 32'h11223344, 32'h0, lat, rd, e, mv, ma, mw, ms, we);
        tests++; if (ms !== 4'b1100 || mw !== 32'h33443344 || ma !== 32'h10) begin
            fails++; $display("FAIL sh_lanes got strb=%b data=%h addr=%h exp 1100/33443344/10", ms, mw, ma); end
        run(1'b1, 3'b010, 32'h20, 32'hCAFEBABE, 32'h0, lat, rd, e, mv, ma, mw, ms, we);
        tests++; if (ms !== 4'b1111 || mw !== 32'hCAFEBABE || e !== 2'b00) begin
            fails++; $display("FAIL sw_lanes got strb=%b data=%h err=%b exp 1111/cafebabe/00", ms, mw, e); end
    endtask

    task automatic test_loads();
        int lat, mv; logic [31:0] rd, ma, mw; logic [1:0] e; logic [3:0] ms; logic we;
        run(1'b0, 3'b001, 32'h202, 32'h0, 32'h80F01234, lat, rd, e, mv, ma, mw, ms, we);
        tests++; if (lat !== 4) begin fails++; $display("FAIL lh_latency got %0d exp 4", lat); end
        tests++; if (rd !== 32'hFFFF80F0) begin fails++; $display("FAIL lh_data got %h exp ffff80f0", rd); end
        tests++; if (ma !== 32'h200 || ms !== 4'b0000 || we !== 1'b0) begin
            fails++; $display("FAIL lh_bus got addr=%h strb=%b we=%b exp 200/0000/0", ma, ms, we); end
        run(1'b0, 3'b101, 32'h202, 32'h0, 32'h80F01234, lat, rd, e, mv, ma, mw, ms, we);
        tests++; if (rd !== 32'h000080F0) begin fails++; $display("FAIL lhu_data got %h exp 000080f0", rd); end
        run(1'b0, 3'b100, 32'h201, 32'h0, 32'h80F01234, lat, rd, e, mv, ma, mw, ms, we);
        tests++; if (rd !== 32'h00000012) begin fails++; $display("FAIL lbu_data got %h exp 00000012", rd); end
        run(1'b0, 3'b000, 32'h203, 32'h0, 32'h80F01234, lat, rd, e, mv, ma, mw, ms, we);
        tests++; if (rd !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_data got %h exp ffffff80", rd); end
        run(1'b0, 3'b010, 32'h204, 32'h0, 32'h80F01234, lat, rd, e, mv, ma, mw, ms, we);
        tests++; if (rd !== 32'h80F01234 || e !== 2'b00) begin fails++; $display("FAIL lw_data got %h err=%b exp 80f01234/00", rd, e); end
    endtask

    task automatic test_errors();
        int lat, mv; logic [31:0] rd, ma, mw; logic [1:0] e; logic [3:0] ms; logic we;
        run(1'b0, 3'b010, 32'h006, 32'h0, 32'hFFFFFFFF, lat, rd, e, mv, ma, mw, ms, we);
        tests++; if (lat !== 2) begin fails++; $display("FAIL lw_mis_latency got %0d exp 2", lat); end
        tests++; if (e !== 2'b01 || rd !== 32'h0) begin fails++; $display("FAIL lw_mis_resp got err=%b rdata=%h exp 01/0", e, rd); end
        tests++; if (mv !== 0) begin fails++; $display("FAIL lw_mis_memvalid got %0d cycles exp 0", mv); end
        run(1'b1, 3'b100, 32'h40, 32'h12345678, 32'h0, lat, rd, e, mv, ma, mw, ms, we);
        tests++; if (e !== 2'b10 || lat !== 2 || mv !== 0) begin
            fails++; $display("FAIL st_illegal got err=%b lat=%0d mv=%0d exp 10/2/0", e, lat, mv); end
        run(1'b0, 3'b011, 32'h41, 32'h0, 32'h0, lat, rd, e, mv, ma, mw, ms, we);
        tests++; if (e !== 2'b10) begin fails++; $display("FAIL ld_illegal_prio got err=%b exp 10", e); end
        run(1'b0, 3'b101, 32'h43, 32'h0, 32'h0, lat, rd, e, mv, ma, mw, ms, we);
        tests++; if (e !== 2'b01 || mv !== 0) begin fails++; $display("FAIL lhu_mis got err=%b mv=%0d exp 01/0", e, mv); end
        run(1'b1, 3'b001, 32'h43, 32'hFFFF, 32'h0, lat, rd, e, mv, ma, mw, ms, we);
        tests++; if (e !== 2'b01) begin fails++; $display("FAIL sh_mis got err=%b exp 01", e); end
    endtask

    task automatic test_timeout();
        int lat, mv; logic [31:0] rd, ma, mw; logic [1:0] e; logic [3:0] ms; logic we;
        logic late;
        bus.mem_ready = 1'b0;
        run(1'b1, 3'b010, 32'h80, 32'h0BADF00D, 32'h0, lat, rd, e, mv, ma, mw, ms, we);
        tests++; if (mv !== 4) begin fails++; $display("FAIL tmo_memvalid_cycles got %0d exp 4", mv); end
        tests++; if (e !== 2'b11 || rd !== 32'h0) begin fails++; $display("FAIL tmo_resp got err=%b rdata=%h exp 11/0", e, rd); end
        tests++; if (lat !== 6 || bus.mem_valid !== 1'b0) begin
            fails++; $display("FAIL tmo_drop got lat=%0d mem_valid=%b exp 6/0", lat, bus.mem_valid); end
        bus.mem_ready  = 1'b1;
        bus.mem_rvalid = 1'b1;
        late = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (bus.resp_valid) late = 1'b1; end
        bus.mem_rvalid = 1'b0;
        tests++; if (late !== 1'b0) begin fails++; $display("FAIL tmo_late_rvalid got resp_valid=%b exp 0", late); end
    endtask

    task automatic test_reset_midway();
        logic late;
        bus.mem_ready  = 1'b1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h5555AAAA;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h300;
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.mem_addr !== 32'h0) begin fails++; $display("FAIL midrst_mem_addr got %h exp 0", bus.mem_addr); end
        tests++; if (bus.req_ready !== 1'b1 || bus.mem_valid !== 1'b0 || bus.mem_we !== 1'b0) begin
            fails++; $display("FAIL midrst_ctrl got ready=%b mv=%b we=%b exp 1/0/0", bus.req_ready, bus.mem_valid, bus.mem_we); end
        tests++; if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            fails++; $display("FAIL midrst_data got rv=%b rd=%h wd=%h exp 0/0/0", bus.resp_valid, bus.resp_rdata, bus.mem_wdata); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        bus.mem_rvalid = 1'b1;
        late = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (bus.resp_valid) late = 1'b1; end
        bus.mem_rvalid = 1'b0;
        tests++; if (late !== 1'b0) begin fails++; $display("FAIL midrst_late_rvalid got resp_valid=%b exp 0", late); end
    endtask

    task automatic test_back_to_back();
        int lat, mv; logic [31:0] rd, ma, mw; logic [1:0] e; logic [3:0] ms; logic we;
        bus.mem_ready = 1'b1;
        run(1'b1, 3'b010, 32'h30, 32'h12345678, 32'h0, lat, rd, e, mv, ma, mw, ms, we);
        tests++; if (lat !== 3 || e !== 2'b00 || mw !== 32'h12345678) begin
            fails++; $display("FAIL b2b_sw got lat=%0d err=%b wd=%h exp 3/00/12345678", lat, e, mw); end
        @(posedge clk); #1;
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready1 got %b exp 1", bus.req_ready); end
        run(1'b0, 3'b010, 32'h30, 32'h0, 32'h12345678, lat, rd, e, mv, ma, mw, ms, we);
        tests++; if (lat !== 4 || e !== 2'b00 || rd !== 32'h12345678) begin
            fails++; $display("FAIL b2b_lw got lat=%0d err=%b rd=%h exp 4/00/12345678", lat, e, rd); end
        @(posedge clk); #1;
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready2 got %b exp 1", bus.req_ready); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.mem_ready  = 1'b1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        test_reset();
        test_stores();
        test_loads();
        test_errors();
        test_timeout();
        test_reset_midway();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
